// File: rtl/tfe_flow_update.sv
// Per-packet flow-state update stage: reads the hash-table entry for a packet,
// classifies it as a new or continuing flow, writes the entry back and emits features.
module tfe_flow_update #(
  parameter logic [33:0] TIMEOUT  = 34'd100000,
  parameter logic [3:0]  WAIT_MAX = 4'd15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_hash,
  input  logic [33:0] in_time,
  output logic [15:0] q_raddr,
  output logic        q_read,
  input  logic [4:0]  q_pkt_cnt,
  input  logic [33:0] q_last_time,
  input  logic        q_word_valid,
  input  logic        q_rdata_valid,
  output logic [15:0] q_waddr,
  output logic        q_wea,
  output logic [39:0] q_wdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_hash,
  output logic [4:0]  out_pkt_cnt,
  output logic [33:0] out_ipd,
  output logic        out_new_flow,
  output logic        err_timeout
);

  typedef enum logic [2:0] {IDLE, READ, WAIT, UPDATE, EMIT} state_t;

  state_t      state, state_next;
  logic [15:0] hash_r;
  logic [33:0] time_r;
  logic [3:0]  wait_cnt;

  logic [33:0] delta;
  logic        is_new;
  logic [4:0]  cnt_next;
  logic [33:0] ipd_next;
  logic        rd_hit;
  logic        wait_expired;

  assign in_ready     = (state == IDLE);
  assign rd_hit       = (state == WAIT) && q_rdata_valid;
  assign wait_expired = (state == WAIT) && !q_rdata_valid && (wait_cnt == WAIT_MAX - 4'd1);

  // Modular subtraction makes timestamp wrap-around transparent.
  assign delta    = time_r - q_last_time;
  assign is_new   = !q_word_valid || (delta > TIMEOUT);
  assign cnt_next = is_new ? 5'd1 :
                    (q_pkt_cnt == 5'd31) ? 5'd31 : q_pkt_cnt + 5'd1;
  assign ipd_next = is_new ? 34'd0 : delta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // UPDATE is the cycle in which the write and the feature record are presented;
  // both are registered on the edge that accepts the read data.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = READ;
      READ:    state_next = WAIT;
      WAIT: begin
        if (q_rdata_valid)     state_next = UPDATE;
        else if (wait_expired) state_next = IDLE;
      end
      UPDATE:  state_next = out_ready ? IDLE : EMIT;
      EMIT:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hash_r       <= '0;
      time_r       <= '0;
      wait_cnt     <= '0;
      q_read       <= 1'b0;
      q_raddr      <= '0;
      q_wea        <= 1'b0;
      q_waddr      <= '0;
      q_wdata      <= '0;
      out_valid    <= 1'b0;
      out_hash     <= '0;
      out_pkt_cnt  <= '0;
      out_ipd      <= '0;
      out_new_flow <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      q_read      <= 1'b0;
      q_wea       <= 1'b0;
      err_timeout <= 1'b0;

      if (state == IDLE && in_valid) begin
        hash_r  <= in_hash;
        time_r  <= in_time;
        q_read  <= 1'b1;
        q_raddr <= in_hash;
      end

      if (state == READ)      wait_cnt <= '0;
      else if (state == WAIT) wait_cnt <= wait_cnt + 4'd1;

      if (wait_expired) err_timeout <= 1'b1;

      if (rd_hit) begin
        q_wea        <= 1'b1;
        q_waddr      <= hash_r;
        q_wdata      <= {cnt_next, time_r, 1'b1};
        out_valid    <= 1'b1;
        out_hash     <= hash_r;
        out_pkt_cnt  <= cnt_next;
        out_ipd      <= ipd_next;
        out_new_flow <= is_new;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tfe_flow_update.sv
// Self-checking bench for tfe_flow_update: directed test-plan cases plus randomized
// packets, all checked against a flow-table reference model held in the bench.
module tb_tfe_flow_update;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [15:0] in_hash;
  logic [33:0] in_time;
  logic [15:0] q_raddr, q_waddr;
  logic        q_read, q_wea;
  logic [4:0]  q_pkt_cnt;
  logic [33:0] q_last_time;
  logic        q_word_valid, q_rdata_valid;
  logic [39:0] q_wdata;
  logic        out_valid, out_ready;
  logic [15:0] out_hash;
  logic [4:0]  out_pkt_cnt;
  logic [33:0] out_ipd;
  logic        out_new_flow, err_timeout;

  always #5 clk = ~clk;

  tfe_flow_update dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_hash(in_hash), .in_time(in_time),
    .q_raddr(q_raddr), .q_read(q_read),
    .q_pkt_cnt(q_pkt_cnt), .q_last_time(q_last_time),
    .q_word_valid(q_word_valid), .q_rdata_valid(q_rdata_valid),
    .q_waddr(q_waddr), .q_wea(q_wea), .q_wdata(q_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_hash(out_hash),
    .out_pkt_cnt(out_pkt_cnt), .out_ipd(out_ipd), .out_new_flow(out_new_flow),
    .err_timeout(err_timeout)
  );

  localparam longint TICKS = 64'h4_0000_0000;
  localparam longint TMO   = 100000;

  // Reference flow table: the bench's view of what the table holds.
  bit [4:0]  mem_cnt   [65536];
  bit [33:0] mem_last  [65536];
  bit        mem_valid [65536];

  int nChecks = 0;
  int nErrors = 0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [15:0] h, input int cnt, input longint last, input bit v);
    mem_cnt[h]   = 5'(cnt);
    mem_last[h]  = 34'(last);
    mem_valid[h] = v;
  endtask

  task automatic applyStimulus(input logic [15:0] h, input logic [33:0] t, input bit respond,
                               input int hold, input int rst_at);
    longint d, exp_cnt, exp_ipd, exp_wdata;
    bit     newf;
    int     end_k;
    bool_dummy: begin end
    d = longint'(t) - longint'(mem_last[h]);
    if (d < 0) d += TICKS;
    newf      = !mem_valid[h] || (d > TMO);
    exp_cnt   = newf ? 1 : ((mem_cnt[h] == 5'd31) ? 31 : longint'(mem_cnt[h]) + 1);
    exp_ipd   = newf ? 0 : d;
    exp_wdata = (exp_cnt << 35) | (longint'(t) << 1) | 1;
    end_k     = respond ? 6 + hold : 18;

    out_ready = (hold == 0);
    checkOutput("in_ready_idle", 64'(in_ready), 64'(1));
    in_valid = 1'b1;
    in_hash  = h;
    in_time  = t;
    @(posedge clk);
    for (int k = 1; k <= end_k; k++) begin
      @(negedge clk);
      in_valid      = (k == 2);
      q_rdata_valid = 1'b0;
      if (k == 2) begin
        in_hash = 16'($urandom);
        in_time = 34'($urandom);
      end
      if (k == 1) begin
        q_rdata_valid = 1'b1;
        q_pkt_cnt     = 5'($urandom);
        q_last_time   = 34'($urandom);
        q_word_valid  = 1'($urandom);
      end
      if (respond && k == 4) begin
        q_rdata_valid = 1'b1;
        q_pkt_cnt     = mem_cnt[h];
        q_last_time   = mem_last[h];
        q_word_valid  = mem_valid[h];
      end
      if (k == 5 + hold) out_ready = 1'b1;

      checkOutput("q_read", 64'(q_read), 64'(k == 1));
      checkOutput("q_wea", 64'(q_wea), 64'(respond && k == 5));
      checkOutput("err_timeout", 64'(err_timeout), 64'(!respond && k == 17));
      checkOutput("in_ready", 64'(in_ready), 64'(respond ? (k == end_k) : (k >= 17)));
      checkOutput("out_valid", 64'(out_valid), 64'(respond && k >= 5 && k <= 5 + hold));
      if (k == 1) checkOutput("q_raddr", 64'(q_raddr), 64'(h));
      if (respond && k == 5) begin
        checkOutput("q_waddr", 64'(q_waddr), 64'(h));
        checkOutput("q_wdata", 64'(q_wdata), exp_wdata);
      end
      if (respond && k >= 5 && k <= 5 + hold) begin
        checkOutput("out_hash", 64'(out_hash), 64'(h));
        checkOutput("out_pkt_cnt", 64'(out_pkt_cnt), exp_cnt);
        checkOutput("out_ipd", 64'(out_ipd), exp_ipd);
        checkOutput("out_new_flow", 64'(out_new_flow), 64'(newf));
      end
      if (k == rst_at) begin
        rst = 1'b1;
        #1;
        checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
        checkOutput("rst_in_ready", 64'(in_ready), 64'(1));
        checkOutput("rst_q_wea", 64'(q_wea), 64'(0));
        checkOutput("rst_q_wdata", 64'(q_wdata), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        break;
      end
    end
    in_valid      = 1'b0;
    q_rdata_valid = 1'b0;
    out_ready     = 1'b1;
    if (respond && (rst_at == 0 || rst_at > 5)) begin
      mem_cnt[h]   = 5'(exp_cnt);
      mem_last[h]  = t;
      mem_valid[h] = 1'b1;
    end
  endtask

  initial begin
    longint     d;
    logic [15:0] h;
    rst = 1'b1;
    in_valid = 1'b0; in_hash = '0; in_time = '0;
    q_pkt_cnt = '0; q_last_time = '0; q_word_valid = 1'b0; q_rdata_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_in_ready", 64'(in_ready), 64'(1));
    checkOutput("reset_out_valid", 64'(out_valid), 64'(0));
    checkOutput("reset_q_read", 64'(q_read), 64'(0));
    checkOutput("reset_q_wea", 64'(q_wea), 64'(0));
    checkOutput("reset_q_wdata", 64'(q_wdata), 64'(0));
    checkOutput("reset_err", 64'(err_timeout), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(16'h0010, 34'd1000, 1'b1, 0, 0);
    preload(16'h0020, 4, 1000, 1'b1);
    applyStimulus(16'h0020, 34'd1500, 1'b1, 0, 0);
    preload(16'h0030, 2, 0, 1'b1);
    applyStimulus(16'h0030, 34'd100000, 1'b1, 0, 0);
    preload(16'h0031, 2, 0, 1'b1);
    applyStimulus(16'h0031, 34'd100001, 1'b1, 0, 0);
    preload(16'h0040, 31, 500, 1'b1);
    applyStimulus(16'h0040, 34'd600, 1'b1, 0, 0);
    preload(16'h0050, 3, 64'h3_FFFF_FFF0, 1'b1);
    applyStimulus(16'h0050, 34'h10, 1'b1, 0, 0);
    applyStimulus(16'h0010, 34'd1200, 1'b1, 10, 0);
    applyStimulus(16'h0070, 34'd5000, 1'b0, 0, 0);
    applyStimulus(16'h0060, 34'd7000, 1'b1, 10, 7);
    applyStimulus(16'h0060, 34'd7100, 1'b1, 0, 0);

    preload(16'h0103, 6, 64'h3_FFFF_F000, 1'b1);
    for (int i = 0; i < 40; i++) begin
      h = 16'h0100 | 16'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       d = longint'($urandom_range(0, 5000));
        1:       d = TMO - 2 + longint'($urandom_range(0, 4));
        2:       d = longint'($urandom_range(100001, 2000000));
        default: d = longint'($urandom_range(0, 300));
      endcase
      applyStimulus(h, 34'((longint'(mem_last[h]) + d) % TICKS),
                    ($urandom_range(0, 7) != 0), int'($urandom_range(0, 3)), 0);
    end

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/tfe_flow_update.md
Name: tfe_flow_update

Overview:
- Per-packet flow-state update stage, directly upstream of the TFE hash query table.
- Accepts one packet descriptor (hash index, timestamp), reads the table entry, and decides new flow vs. continuing flow.
- Writes back the updated entry {pkt_cnt, last_time, valid} and emits per-packet features (count, inter-packet delay, new-flow flag) to the feature extractor.
- One packet in flight at a time, so there is no read-after-write hazard.

Parameters:
- TIMEOUT, 34'd100000: flow idle timeout in timestamp ticks. A delta strictly greater than this starts a new flow.
- WAIT_MAX, 4'd15: cycles allowed in WAIT for q_rdata_valid before abort.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- in_valid  in  1  packet descriptor valid
- in_ready  out  1  stage can accept a descriptor
- in_hash  in  16  table index
- in_time  in  34  packet timestamp
- q_raddr  out  16  table read address
- q_read  out  1  table read enable (one-cycle pulse)
- q_pkt_cnt  in  5  table read pkt_cnt
- q_last_time  in  34  table read last_time
- q_word_valid  in  1  table entry valid bit
- q_rdata_valid  in  1  table read data valid (3 cycles after q_read)
- q_waddr  out  16  table write address
- q_wea  out  1  table write enable
- q_wdata  out  40  {pkt_cnt[39:35], last_time[34:1], valid[0]}
- out_valid  out  1  feature record valid
- out_ready  in  1  downstream accepts record
- out_hash  out  16  flow index
- out_pkt_cnt  out  5  updated packet count
- out_ipd  out  34  inter-packet delay
- out_new_flow  out  1  packet opened a new flow
- err_timeout  out  1  one-cycle pulse on WAIT abort

Behaviour:
- Reset: rst is asynchronous, active-high; clock clk. While rst is high:
  - state = IDLE.
  - All registered outputs are 0 (q_read, q_wea, q_raddr, q_waddr, q_wdata, out_*, err_timeout).
  - in_ready = 1; it is decoded from state == IDLE.
- Reset mid-operation drops the packet in flight with no write and no record.
- States: IDLE, READ, WAIT, UPDATE, EMIT.
- IDLE: in_ready = 1. When in_valid is high, capture in_hash and in_time and go to READ.
- READ (1 cycle): q_read = 1, q_raddr = captured hash. Clear the wait counter. Go to WAIT.
- WAIT:
  - Increment the wait counter each cycle.
  - If q_rdata_valid is high, capture the q_* read fields and go to UPDATE.
  - Else if the counter reaches WAIT_MAX, pulse err_timeout for one cycle and go to IDLE with no write.
- UPDATE (1 cycle), with delta = in_time - q_last_time (34-bit modular, so timestamp wrap is handled):
  - new = !q_word_valid || (delta > TIMEOUT). delta == TIMEOUT counts as continuing.
  - If new: cnt = 1, ipd = 0.
  - Else: cnt = q_pkt_cnt + 1, saturating at 31; ipd = delta.
  - Register q_wea = 1 (exactly one cycle), q_waddr = hash, q_wdata = {cnt, in_time, 1'b1}.
  - Register out_valid = 1 plus out_hash, out_pkt_cnt = cnt, out_ipd = ipd, out_new_flow = new.
  - Go to EMIT.
- EMIT:
  - q_wea = 0.
  - Hold out_valid and all out_* fields stable until out_ready is high.
  - On out_valid && out_ready: clear out_valid and go to IDLE.
- Latency:
  - Accept edge T.
  - q_read is high during cycle T+1.
  - q_rdata_valid is seen in cycle T+4.
  - q_wea and out_valid are high in cycle T+5.
  - With out_ready held high, in_ready returns in cycle T+6.
  - Throughput is one packet per 6 cycles.
- in_valid while not IDLE is ignored; upstream must hold the descriptor.
- q_rdata_valid outside WAIT is ignored.

Test Plan:
- Empty entry: reset, then in_hash=16'h0010, in_time=1000. The table returns word_valid=0. Required: q_wdata={5'd1, 34'd1000, 1'b1}, out_new_flow=1, out_ipd=0, out_pkt_cnt=1, q_wea high exactly at T+5.
- Continuing flow: entry {cnt=4, last=1000, valid=1}, in_time=1500. Required: out_pkt_cnt=5, out_ipd=500, out_new_flow=0, q_wdata={5, 1500, 1}.
- Timeout boundary:
  - Entry last=0, in_time=100000 → continuing, ipd=100000.
  - Entry last=0, in_time=100001 → new_flow=1, cnt=1.
- Saturation and wrap:
  - Entry cnt=31, continuing → out_pkt_cnt=31.
  - last=34'h3FFFFFFF0, in_time=34'h10 → ipd=32, continuing.
- Backpressure: hold out_ready=0 for 10 cycles. Required: out fields stable, in_ready=0 throughout, q_wea pulses once only. Release out_ready → in_ready=1 on the next cycle.
- Abort and reset:
  - Never assert q_rdata_valid → err_timeout pulses once 15 cycles after WAIT entry, no q_wea, return to IDLE.
  - Assert rst during EMIT → out_valid=0 immediately (async), in_ready=1.
